// File: rtl/video_cmd_sequencer.sv
// video_cmd_sequencer: FIFO-buffered, strictly in-order issue of bank/sprite writes and status queries.
// Writes are held back while the monitor prints a frame; undefined opcodes are discarded and flagged.
module video_cmd_sequencer #(
    parameter int OPCODE_W   = 4,
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 8,
    parameter int NUM_FIELDS = 3,
    parameter int OP_MEM     = 3,
    parameter int OP_STATUS  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                instr_valid,
    input  logic [OPCODE_W-1:0] instr_opcode,
    input  logic [DATA_W-1:0]   instr_data,
    output logic                instr_ready,
    input  logic                printing_screen,
    output logic                busy,
    output logic                reg_wr,
    output logic [OPCODE_W-1:0] reg_field,
    output logic                mem_wr,
    output logic [DATA_W-1:0]   wr_data,
    output logic                mux_file_register,
    output logic                mux_out,
    output logic                status_valid,
    output logic                status_busy,
    output logic                illegal_op
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, DECODE, WAIT_PRINT, EXEC_BANK, EXEC_MEM, STATUS} state_t;

    state_t              state;
    logic [OPCODE_W-1:0] fifo_op   [DEPTH];
    logic [DATA_W-1:0]   fifo_data [DEPTH];
    logic [PTR_W-1:0]    rd_ptr, wr_ptr;
    logic [PTR_W:0]      count;
    logic [OPCODE_W-1:0] head_op;
    logic [DATA_W-1:0]   head_data;
    logic                is_bank, is_mem, is_status, push, pop;

    assign head_op     = fifo_op[rd_ptr];
    assign head_data   = fifo_data[rd_ptr];
    assign is_bank     = head_op < OPCODE_W'(NUM_FIELDS);
    assign is_mem      = head_op == OPCODE_W'(OP_MEM);
    assign is_status   = head_op == OPCODE_W'(OP_STATUS);
    assign instr_ready = count != FULL;
    assign push        = instr_valid && instr_ready;
    // The head leaves the FIFO as its issue cycle ends, or straight out of DECODE when it is undefined.
    assign pop         = state == EXEC_BANK || state == EXEC_MEM || state == STATUS ||
                         (state == DECODE && !(is_bank || is_mem || is_status));
    assign busy        = count != '0 || state != IDLE;
    assign status_busy = status_valid && printing_screen;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_op[wr_ptr]   <= instr_opcode;
            fifo_data[wr_ptr] <= instr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    // Outputs are registered alongside the state so each one reflects the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            reg_wr            <= 1'b0;
            reg_field         <= '0;
            mem_wr            <= 1'b0;
            wr_data           <= '0;
            mux_file_register <= 1'b0;
            mux_out           <= 1'b0;
            status_valid      <= 1'b0;
            illegal_op        <= 1'b0;
        end else begin
            reg_wr            <= 1'b0;
            reg_field         <= '0;
            mem_wr            <= 1'b0;
            wr_data           <= '0;
            mux_file_register <= 1'b0;
            mux_out           <= 1'b0;
            status_valid      <= 1'b0;
            illegal_op        <= 1'b0;
            case (state)
                IDLE:
                    if (count != '0)
                        state <= DECODE;
                DECODE:
                    if ((is_bank || is_mem) && printing_screen)
                        state <= WAIT_PRINT;
                    else if (is_bank) begin
                        state             <= EXEC_BANK;
                        reg_wr            <= 1'b1;
                        reg_field         <= head_op;
                        wr_data           <= head_data;
                        mux_file_register <= 1'b1;
                        mux_out           <= 1'b1;
                    end else if (is_mem) begin
                        state   <= EXEC_MEM;
                        mem_wr  <= 1'b1;
                        wr_data <= head_data;
                        mux_out <= 1'b1;
                    end else if (is_status) begin
                        state        <= STATUS;
                        status_valid <= 1'b1;
                    end else begin
                        state      <= IDLE;
                        illegal_op <= 1'b1;
                    end
                WAIT_PRINT:
                    if (!printing_screen)
                        state <= DECODE;
                default:
                    state <= IDLE;
            endcase
        end
    end
endmodule
